// File: rtl/irq_sequencer.sv
// Interrupt/exception sequencer: synchronises the timer IRQ, waits for a safe
// ID-stage slot, strobes the decoder, and tracks kernel mode, EPC and cause.
//
// state  | meaning
// USER   | user mode, watching for exceptions and interrupts
// PEND   | interrupt seen, waiting for a safe instruction slot
// TAKE   | one-cycle interrupt strobe, capture epc
// KERNEL | kernel mode, interrupts and exceptions masked
// RET    | one-cycle kernel return, clear cause
module irq_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq_in,
    input  logic        exc_in,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic        stall_in,
    input  logic        branch_pending,
    input  logic        eret_in,
    output logic        supervise,
    output logic        irq_out,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        irq_starve
);

    typedef enum logic [2:0] {
        USER   = 3'd0,
        PEND   = 3'd1,
        TAKE   = 3'd2,
        KERNEL = 3'd3,
        RET    = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic        irq_meta, irq_s;
    logic [3:0]  wait_cnt;
    logic        starve_q;
    logic        safe, exc_ok, eret_ok, starve_now;

    assign safe       = id_valid & ~stall_in & ~branch_pending;
    assign exc_ok     = exc_in & id_valid & ~stall_in;
    assign eret_ok    = eret_in & id_valid & ~stall_in;
    assign starve_now = (state == PEND) && (wait_cnt == 4'hf);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_meta <= 1'b0;
            irq_s    <= 1'b0;
            state    <= USER;
        end else begin
            irq_meta <= irq_in;
            irq_s    <= irq_meta;
            state    <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            USER: begin
                if (exc_ok)
                    state_nx = KERNEL;
                else if (irq_s)
                    state_nx = PEND;
            end
            PEND: begin
                // an exception in the same slot wins over the interrupt
                if (exc_ok)
                    state_nx = KERNEL;
                else if (!irq_s)
                    state_nx = USER;
                else if (safe)
                    state_nx = TAKE;
            end
            TAKE:    state_nx = KERNEL;
            KERNEL: begin
                if (eret_ok)
                    state_nx = RET;
            end
            RET:     state_nx = USER;
            default: state_nx = USER;
        endcase
    end

    always_comb begin
        supervise  = (state == KERNEL) || (state == RET);
        irq_out    = (state == TAKE);
        irq_starve = starve_q | starve_now;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc   <= 32'h0;
            cause <= 2'b00;
        end else begin
            case (state)
                USER, PEND: begin
                    if (exc_ok) begin
                        epc   <= id_pc;
                        cause <= 2'b10;
                    end
                end
                TAKE: begin
                    epc   <= id_pc;
                    cause <= 2'b01;
                end
                RET:     cause <= 2'b00;
                default: ;
            endcase
        end
    end

    // wait counter lives only while PEND persists; saturates at 15
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 4'h0;
            starve_q <= 1'b0;
        end else begin
            if ((state == PEND) && (state_nx == PEND))
                wait_cnt <= (wait_cnt == 4'hf) ? wait_cnt : wait_cnt + 4'h1;
            else
                wait_cnt <= 4'h0;
            starve_q <= starve_q | starve_now;
        end
    end

endmodule

// File: doc/irq_sequencer.md
IRQ_SEQUENCER -- requirements
Module: irq_sequencer

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 irq_in  input  1  external timer interrupt request, asynchronous to clk, level-sensitive.
REQ-005 exc_in  input  1  undefined-instruction flag for the ID-stage instruction, from the decoder.
REQ-006 id_valid  input  1  ID stage holds a real instruction, not a bubble.
REQ-007 id_pc  input  32  PC of the ID-stage instruction.
REQ-008 stall_in  input  1  load-use stall active this cycle.
REQ-009 branch_pending  input  1  branch or jump in EX not yet resolved.
REQ-010 eret_in  input  1  ID-stage instruction is the kernel return (jr $26).
REQ-011 supervise  output  1  kernel-mode bit; drives the decoder Supervise input.
REQ-012 irq_out  output  1  one-cycle interrupt-take strobe; drives the decoder IRQ input.
REQ-013 epc  output  32  exception return address.
REQ-014 cause  output  2  00 none, 01 interrupt, 10 exception.
REQ-015 irq_starve  output  1  sticky flag: a pending interrupt waited more than 15 cycles.

Function
REQ-016 SHALL synchronise irq_in through two flops (irq_s) before any use; irq_in-to-irq_s latency is 2 cycles.
REQ-017 SHALL implement states USER, PEND, TAKE, KERNEL, RET.
REQ-018 safe = id_valid & ~stall_in & ~branch_pending.
REQ-019 USER: supervise=0; exc_in & id_valid & ~stall_in -> KERNEL, epc<=id_pc, cause<=10; else irq_s -> PEND.
REQ-020 PEND: supervise=0, irq_out=0; exc_in & id_valid & ~stall_in -> KERNEL with cause 10, which takes priority over the interrupt; else safe -> TAKE; else stay.
REQ-021 PEND exit on irq_s deassertion: if irq_s drops before the interrupt is taken, return to USER with no side effects.
REQ-022 TAKE: irq_out=1 for exactly this cycle, supervise=0, epc<=id_pc, cause<=01; next state KERNEL unconditionally.
REQ-023 KERNEL: supervise=1, irq_out=0; irq_s and exc_in are ignored, so no nesting occurs.
REQ-024 KERNEL exit: eret_in & id_valid & ~stall_in -> RET.
REQ-025 RET: supervise=1 for this one cycle, cause<=00; next state USER.
REQ-026 An interrupt still asserted on entry to USER from RET SHALL re-enter PEND the following cycle.
REQ-027 Wait counter: a 4-bit counter increments each cycle in PEND, saturates at 15, and clears on leaving PEND.
REQ-028 irq_starve SHALL set when the counter is 15 while still in PEND, and clear only on reset.
REQ-029 epc and cause SHALL change only on the transitions named above and hold otherwise.
REQ-030 irq_out SHALL never be asserted while supervise=1.

Reset
REQ-031 reset=0 SHALL force state=USER, supervise=0, irq_out=0, epc=32'h0, cause=00, irq_starve=0, counter=0, and synchroniser flops=0.
REQ-032 Reset asserted in any state, including TAKE, SHALL abort without completing the transition; irq_out falls asynchronously.
REQ-033 After reset release, the first possible irq_out is no earlier than 3 cycles after irq_in is observed high.

Verification
REQ-034 irq_in=1 in USER, safe=1, id_pc=0x00400010 -> PEND after 2 cycles, then irq_out=1 for exactly 1 cycle, epc=0x00400010, cause=01, then supervise=1.
REQ-035 PEND with branch_pending=1 for 5 cycles -> irq_out stays 0 for those 5 cycles, then TAKE on the first cycle with branch_pending=0.
REQ-036 exc_in=1 and irq_s=1 in the same PEND cycle, id_pc=0x00400020 -> KERNEL, cause=10, epc=0x00400020, irq_out=0 throughout.
REQ-037 In KERNEL, pulse irq_in, then eret_in with id_valid=1 -> RET for 1 cycle, USER, then PEND if irq_in is still high; supervise falls exactly 2 cycles after eret is accepted.
REQ-038 PEND with stall_in=1 held for 20 cycles -> irq_starve=1 from the 16th PEND cycle, staying 1 after the interrupt is taken.
REQ-039 reset=0 pulsed mid-TAKE -> all outputs at reset values immediately; epc=0 and no KERNEL entry.
